// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN stack controller.
package rpn_pkg;

   localparam int unsigned OPCODE_W = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PUSH      = 3'd1,
      POP_B     = 3'd2,
      POP_A     = 3'd3,
      EXEC      = 3'd4,
      WRITEBACK = 3'd5,
      UNDO      = 3'd6,
      ERROR     = 3'd7
   } rpnState_t;

   typedef enum logic [1:0] {
      UNDO_NONE = 2'd0,
      UNDO_PUSH = 2'd1,
      UNDO_EXEC = 2'd2
   } undoKind_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// Pulse/operand/ALU/status bundle between the RPN controller and its environment.
interface rpn_stack_ctrl_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
);
   import rpn_pkg::*;

   localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]    DataIn;
   logic [OPCODE_W-1:0] OpCodeIn;
   logic                EnterPulse;
   logic                ExecPulse;
   logic                UndoPulse;
   logic [WIDTH-1:0]    AluResult;

   logic [WIDTH-1:0]    out_OperandA;
   logic [WIDTH-1:0]    out_OperandB;
   logic [OPCODE_W-1:0] out_OpCode;
   logic [WIDTH-1:0]    out_Top;
   logic [DEPTH_W-1:0]  out_Depth;
   logic                out_Busy;
   logic                out_Error;
   logic [2:0]          out_Status;

   modport master (
      output DataIn, OpCodeIn, EnterPulse, ExecPulse, UndoPulse, AluResult,
      input  out_OperandA, out_OperandB, out_OpCode, out_Top, out_Depth,
             out_Busy, out_Error, out_Status
   );

   modport slave (
      input  DataIn, OpCodeIn, EnterPulse, ExecPulse, UndoPulse, AluResult,
      output out_OperandA, out_OperandB, out_OpCode, out_Top, out_Depth,
             out_Busy, out_Error, out_Status
   );

endinterface

// File: rtl/rpn_operand_stack.sv
// Operand stack: register array plus entry count; push, pop and top-overwrite ports.
module rpn_operand_stack #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic [WIDTH-1:0]   pushData,
   input  logic               pop,
   input  logic               overwrite,
   input  logic [WIDTH-1:0]   overwriteData,
   output logic [WIDTH-1:0]   top,
   output logic [DEPTH_W-1:0] depth
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   entries [DEPTH];
   logic [DEPTH_W-1:0] count;
   logic [IDX_W-1:0]   topIdx;
   logic [IDX_W-1:0]   freeIdx;

   assign freeIdx = IDX_W'(count);
   assign topIdx  = IDX_W'(count - DEPTH_W'(1));

   // Overwrite targets the current top; push targets the first free slot, so both may fire together.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (overwrite) entries[topIdx] <= overwriteData;
         if (push) entries[freeIdx] <= pushData;
         count <= count + DEPTH_W'(push) - DEPTH_W'(pop);
      end
   end

   assign top   = (count == '0) ? '0 : entries[topIdx];
   assign depth = count;

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Reverse-Polish sequencing controller for the calculator ALU datapath.
// Optional single-level undo is built when RPN_UNDO_EN is defined.
module rpn_stack_ctrl
   import rpn_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   rpn_stack_ctrl_if.slave  bus
);

   localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

   rpnState_t          state;
   rpnState_t          nextState;
   logic [WIDTH-1:0]   hold;
   logic [WIDTH-1:0]   stackTop;
   logic [DEPTH_W-1:0] depth;
   logic               pushEn;
   logic               popEn;
   logic               overwriteEn;
   logic [WIDTH-1:0]   pushData;
   logic               holdLoad;
   logic               opLoad;
   logic               loadA;
   logic               loadB;
   logic               anyPulse;

`ifdef RPN_UNDO_EN
   undoKind_t undoKind;
   undoKind_t undoKindNext;

   assign anyPulse = bus.EnterPulse | bus.ExecPulse | bus.UndoPulse;
`else
   logic unusedUndo;

   assign unusedUndo = bus.UndoPulse;
   assign anyPulse   = bus.EnterPulse | bus.ExecPulse;
`endif

   rpn_operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) u_stack (
      .clk           (clk),
      .reset         (reset),
      .push          (pushEn),
      .pushData      (pushData),
      .pop           (popEn),
      .overwrite     (overwriteEn),
      .overwriteData (bus.out_OperandA),
      .top           (stackTop),
      .depth         (depth)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state and stack sequencing; pulses are only looked at in IDLE and ERROR.
   always_comb begin
      nextState   = state;
      pushEn      = 1'b0;
      popEn       = 1'b0;
      overwriteEn = 1'b0;
      pushData    = hold;
      holdLoad    = 1'b0;
      opLoad      = 1'b0;
      loadA       = 1'b0;
      loadB       = 1'b0;
`ifdef RPN_UNDO_EN
      undoKindNext = undoKind;
`endif
      case (state)
         IDLE: begin
            if (bus.EnterPulse) begin
               if (depth == DEPTH_W'(DEPTH)) begin
                  nextState = ERROR;
               end else begin
                  holdLoad  = 1'b1;
                  nextState = PUSH;
               end
            end else if (bus.ExecPulse) begin
               if (depth < DEPTH_W'(2)) begin
                  nextState = ERROR;
               end else begin
                  opLoad    = 1'b1;
                  nextState = POP_B;
               end
            end
`ifdef RPN_UNDO_EN
            else if (bus.UndoPulse && (undoKind != UNDO_NONE)) begin
               nextState = UNDO;
            end
            if (nextState == ERROR) undoKindNext = UNDO_NONE;
`endif
         end
         PUSH: begin
            pushEn    = 1'b1;
            nextState = IDLE;
`ifdef RPN_UNDO_EN
            undoKindNext = UNDO_PUSH;
`endif
         end
         POP_B: begin
            popEn     = 1'b1;
            loadB     = 1'b1;
            nextState = POP_A;
         end
         POP_A: begin
            popEn     = 1'b1;
            loadA     = 1'b1;
            nextState = EXEC;
         end
         EXEC: nextState = WRITEBACK;
         WRITEBACK: begin
            pushEn    = 1'b1;
            pushData  = bus.AluResult;
            nextState = IDLE;
`ifdef RPN_UNDO_EN
            undoKindNext = UNDO_EXEC;
`endif
         end
         UNDO: begin
`ifdef RPN_UNDO_EN
            // Exec undo: result slot gets A back, then B is pushed on top of it.
            if (undoKind == UNDO_PUSH) begin
               popEn = 1'b1;
            end else if (undoKind == UNDO_EXEC) begin
               overwriteEn = 1'b1;
               pushEn      = 1'b1;
               pushData    = bus.out_OperandB;
            end
            undoKindNext = UNDO_NONE;
`endif
            nextState = IDLE;
         end
         ERROR: begin
            if (anyPulse) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

`ifdef RPN_UNDO_EN
   always_ff @(posedge clk) begin
      if (reset) undoKind <= UNDO_NONE;
      else       undoKind <= undoKindNext;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         hold             <= '0;
         bus.out_OperandA <= '0;
         bus.out_OperandB <= '0;
         bus.out_OpCode   <= '0;
      end else begin
         if (holdLoad) hold             <= bus.DataIn;
         if (opLoad)   bus.out_OpCode   <= bus.OpCodeIn;
         if (loadB)    bus.out_OperandB <= stackTop;
         if (loadA)    bus.out_OperandA <= stackTop;
      end
   end

   assign bus.out_Top    = stackTop;
   assign bus.out_Depth  = depth;
   assign bus.out_Status = 3'(state);
   assign bus.out_Busy   = (state != IDLE) && (state != ERROR);
   assign bus.out_Error  = (state == ERROR);

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl: randomized pulses against a queue-based stack model.
module tb_rpn_stack_ctrl;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DEPTH = 4;
`ifdef RPN_UNDO_EN
   localparam bit UNDO_ON = 1'b1;
`else
   localparam bit UNDO_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] status;
      logic [31:0] depth;
      logic [31:0] top;
      logic [31:0] cyc;
      logic        ops;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] op;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int unsigned cyc = 0;
   exp_t expQ[$];

   int unsigned mStack[$];
   bit          mErr = 1'b0;
   int          mRec = 0;
   int unsigned mA = 0;
   int unsigned mB = 0;

   rpn_stack_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned aluRef(int unsigned a, int unsigned b, int unsigned op);
      int unsigned r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a * b;
         6: r = a;
         default: r = b;
      endcase
      return r & 32'hFFFF;
   endfunction

   assign bus.AluResult = 16'(aluRef(32'(bus.out_OperandA), 32'(bus.out_OperandB), 32'(bus.out_OpCode)));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int unsigned mTop();
      return (mStack.size() > 0) ? mStack[$] : 0;
   endfunction

   // Monitor: every return to IDLE or entry to ERROR is one completed response.
   int unsigned prevStatus = 0;
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prevStatus = 0;
      end else begin
         if ((32'(bus.out_Status) != prevStatus) && (bus.out_Status == 3'd0 || bus.out_Status == 3'd7)) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: status %0d with nothing expected (cycle %0d)", bus.out_Status, cyc);
            end else begin
               e = expQ.pop_front();
               chk("status", 32'(bus.out_Status), e.status);
               chk("latency", cyc, e.cyc);
               chk("depth", 32'(bus.out_Depth), e.depth);
               chk("top", 32'(bus.out_Top), e.top);
               chk("error_flag", 32'(bus.out_Error), (e.status == 7) ? 1 : 0);
               chk("busy_flag", 32'(bus.out_Busy), 0);
               if (e.ops) begin
                  chk("operandA", 32'(bus.out_OperandA), e.a);
                  chk("operandB", 32'(bus.out_OperandB), e.b);
                  chk("opcode", 32'(bus.out_OpCode), e.op);
               end
            end
         end
         prevStatus = 32'(bus.out_Status);
      end
   end

   task automatic clearPulses();
      bus.EnterPulse = 1'b0;
      bus.ExecPulse  = 1'b0;
      bus.UndoPulse  = 1'b0;
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_status"}, 32'(bus.out_Status), 0);
      chk({tag, "_depth"}, 32'(bus.out_Depth), 0);
      chk({tag, "_top"}, 32'(bus.out_Top), 0);
      chk({tag, "_opA"}, 32'(bus.out_OperandA), 0);
      chk({tag, "_opB"}, 32'(bus.out_OperandB), 0);
      chk({tag, "_opcode"}, 32'(bus.out_OpCode), 0);
      chk({tag, "_busy"}, 32'(bus.out_Busy), 0);
      chk({tag, "_error"}, 32'(bus.out_Error), 0);
   endtask

   task automatic modelReset();
      mStack.delete();
      expQ.delete();
      mErr = 1'b0;
      mRec = 0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      clearPulses();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      modelReset();
   endtask

   // Issue one pulse combination from IDLE/ERROR, predict the response, optionally inject ignored pulses while busy.
   task automatic doCmd(input bit en, input bit ex, input bit un, input logic [15:0] d,
                        input logic [2:0] op, input bit noise);
      exp_t e;
      bit ev;
      int lat;
      int unsigned a, b;
      e = '0;
      ev = 1'b0;
      lat = 1;
      if (mErr) begin
         if (en || ex || (UNDO_ON && un)) begin
            mErr = 1'b0;
            ev = 1'b1;
         end
      end else if (en) begin
         ev = 1'b1;
         if (mStack.size() == DEPTH) begin
            mErr = 1'b1; mRec = 0; e.status = 7;
         end else begin
            mStack.push_back(32'(d)); mRec = 1; lat = 2;
         end
      end else if (ex) begin
         ev = 1'b1;
         if (mStack.size() < 2) begin
            mErr = 1'b1; mRec = 0; e.status = 7;
         end else begin
            b = mStack.pop_back();
            a = mStack.pop_back();
            mStack.push_back(aluRef(a, b, 32'(op)));
            mA = a; mB = b; mRec = 2; lat = 5;
            e.ops = 1'b1; e.a = a; e.b = b; e.op = 32'(op);
         end
      end else if (UNDO_ON && un && mRec != 0) begin
         ev = 1'b1;
         lat = 2;
         void'(mStack.pop_back());
         if (mRec == 2) begin
            mStack.push_back(mA);
            mStack.push_back(mB);
         end
         mRec = 0;
      end
      e.depth = mStack.size();
      e.top = mTop();
      e.cyc = cyc + lat;
      if (ev) expQ.push_back(e);
      bus.DataIn = d; bus.OpCodeIn = op;
      bus.EnterPulse = en; bus.ExecPulse = ex; bus.UndoPulse = un;
      @(posedge clk); #1;
      clearPulses();
      for (int i = 1; i < lat; i++) begin
         if (noise) begin
            bus.DataIn     = 16'($urandom);
            bus.OpCodeIn   = 3'($urandom_range(0, 7));
            bus.EnterPulse = 1'($urandom_range(0, 1));
            bus.ExecPulse  = 1'($urandom_range(0, 1));
            bus.UndoPulse  = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         clearPulses();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      bus.DataIn = '0;
      bus.OpCodeIn = '0;
      clearPulses();
      doReset();
      chkZero("reset");

      // 5 + 3 on a fresh stack
      doCmd(1, 0, 0, 16'd5, 3'd0, 0);
      doCmd(1, 0, 0, 16'd3, 3'd0, 0);
      doCmd(0, 1, 0, 16'd0, 3'd0, 0);

      // fill to DEPTH, overflow, leave ERROR with a consumed Enter
      doCmd(1, 0, 0, 16'd1, 3'd0, 0);
      doCmd(1, 0, 0, 16'd2, 3'd0, 0);
      doCmd(1, 0, 0, 16'd4, 3'd0, 0);
      doCmd(1, 0, 0, 16'd9, 3'd0, 0);
      doCmd(1, 0, 0, 16'd9, 3'd0, 0);

      // underflow with one entry
      doReset();
      doCmd(1, 0, 0, 16'd6, 3'd0, 0);
      doCmd(0, 1, 0, 16'd0, 3'd1, 0);
      doCmd(0, 1, 0, 16'd0, 3'd1, 0);

      // Enter wins over Exec; busy-time pulses are ignored
      doCmd(1, 0, 0, 16'd10, 3'd0, 0);
      doCmd(1, 1, 0, 16'd11, 3'd0, 0);
      doCmd(0, 1, 0, 16'd0, 3'd4, 1);

      // reset while in EXEC
      bus.OpCodeIn = 3'd5;
      bus.ExecPulse = 1'b1;
      @(posedge clk); #1;
      clearPulses();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("in_exec_status", 32'(bus.out_Status), 4);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      modelReset();
      chkZero("midreset");

      // undo of a subtract, then an undo with no record
      doCmd(1, 0, 0, 16'd7, 3'd0, 0);
      doCmd(1, 0, 0, 16'd2, 3'd0, 0);
      doCmd(0, 1, 0, 16'd0, 3'd1, 0);
      doCmd(0, 0, 1, 16'd0, 3'd0, 0);
      doCmd(0, 0, 1, 16'd0, 3'd0, 0);
      chk("after_undo_depth", 32'(bus.out_Depth), mStack.size());
      chk("after_undo_top", 32'(bus.out_Top), mTop());

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 49);
         if (r == 0) begin
            doReset();
         end else begin
            r = r % 10;
            doCmd(r <= 3 || r == 8, (r >= 4 && r <= 6) || r >= 8, r == 7 || r == 9,
                  16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
      end

      repeat (10) @(posedge clk);
      #1;
      chk("queue_drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
